// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// The parity feature is selected with the UART_PARITY_EN macro.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic UART_IDLE_LVL = 1'b1;
  localparam logic START_LVL     = 1'b0;

  // Index width for n requesters, never below one bit
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot winner is the first set request
// found searching upward from rr_ptr_i+1, wrapping.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = ptr_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] win_c
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    win_c = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = PTR_W'((32'(rr_ptr_i) + i) % NUM_REQ);
      if (!found && req_i[idx]) begin
        win_c[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmit line between NUM_REQ byte requesters (round-robin).
// Define UART_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bclk,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic                      busy,
  output logic                      tx
);

  localparam int unsigned PTR_W = ptr_w(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam int unsigned SC_W  = 2;

  state_e              state_q, state_d;
  logic                bclk_q;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SC_W-1:0]     stop_cnt_q, stop_cnt_d;
  logic                tx_q, tx_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                busy_q, busy_d;
`ifdef UART_PARITY_EN
  logic                parity_q, parity_d;
`endif

  logic                tick_c;
  logic [NUM_REQ-1:0]  win_c;
  logic [PTR_W-1:0]    win_idx_c;
  logic [DATA_W-1:0]   win_byte_c;

  assign tick_c = bclk & ~bclk_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .win_c    (win_c)
  );

  // Encode the one-hot winner and select its byte
  always_comb begin
    win_idx_c  = '0;
    win_byte_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_c[i]) begin
        win_idx_c  = PTR_W'(i);
        win_byte_c = data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bclk_q     <= 1'b0;
      rr_ptr_q   <= PTR_W'(NUM_REQ - 1);
      owner_q    <= '0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      tx_q       <= UART_IDLE_LVL;
      gnt_q      <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
`ifdef UART_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bclk_q     <= bclk;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
`ifdef UART_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    gnt_d      = '0;
    done_d     = '0;
    busy_d     = busy_q;
`ifdef UART_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      IDLE: begin
        // The done cycle is spent in IDLE without arbitrating
        busy_d = 1'b0;
        if (done_q == '0 && req != '0) begin
          gnt_d    = win_c;
          owner_d  = win_idx_c;
          rr_ptr_d = win_idx_c;
          shreg_d  = win_byte_c;
          busy_d   = 1'b1;
          state_d  = START;
`ifdef UART_PARITY_EN
          parity_d = ^win_byte_c;
`endif
        end
      end
      START: begin
        if (tick_c && gnt_q == '0) begin
          tx_d      = START_LVL;
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (tick_c) begin
          tx_d      = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            stop_cnt_d = '0;
`ifdef UART_PARITY_EN
            state_d    = PARITY;
`else
            state_d    = STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (tick_c) begin
          tx_d       = parity_q;
          stop_cnt_d = '0;
          state_d    = STOP;
        end
      end
`endif
      STOP: begin
        if (tick_c) begin
          tx_d       = UART_IDLE_LVL;
          stop_cnt_d = stop_cnt_q + SC_W'(1);
          if (stop_cnt_q == SC_W'(STOP_BITS)) begin
            done_d[owner_q] = 1'b1;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;
  assign tx   = tx_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: frame-level reference model plus directed tests.
module tb_uart_tx_scheduler;

  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned STOP_BITS = 1;
  localparam int unsigned BIT_CYC   = 8;
`ifdef UART_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  localparam int unsigned NBITS  = 1 + DATA_W + PAR + STOP_BITS;
  localparam int          BUDGET = NBITS * BIT_CYC + 60;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      bclk = 1'b0;
  logic                      bclk_run = 1'b1;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ*DATA_W-1:0] data = '0;
  logic [NUM_REQ-1:0]        gnt, done;
  logic                      busy, tx;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;
  bit width_en = 0;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .STOP_BITS(STOP_BITS)
  ) dut (
    .clk(clk), .rst(rst), .bclk(bclk), .req(req), .data(data),
    .gnt(gnt), .done(done), .busy(busy), .tx(tx)
  );

  int bcnt = 0;
  always @(posedge clk) begin
    #2;
    if (bclk_run) begin
      if (bcnt == int'(BIT_CYC / 2) - 1) begin
        bcnt = 0;
        bclk = ~bclk;
      end else begin
        bcnt++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a granted frame is a list of line levels, one per bit tick
  logic [NUM_REQ-1:0] e_gnt, e_done;
  logic               e_busy, e_tx;
  bit                 m_active, m_first, m_done_pend, m_prev, m_sent;
  int                 m_rr, m_owner, m_k;
  bit                 m_bits[$];

  always @(posedge clk or posedge rst) begin
    bit tk;
    bit found;
    int w;
    logic [DATA_W-1:0] byte_v;
    if (rst) begin
      e_gnt = '0; e_done = '0; e_busy = 1'b0; e_tx = 1'b1;
      m_active = 0; m_first = 0; m_done_pend = 0; m_prev = 0; m_sent = 0;
      m_rr = NUM_REQ - 1; m_k = 0;
    end else begin
      tk = bclk && !m_prev;
      m_prev = bclk;
      m_sent = 0;
      e_gnt = '0;
      e_done = '0;
      if (!m_active) begin
        if (m_done_pend) begin
          m_done_pend = 0;
          e_busy = 1'b0;
        end else if (req != '0) begin
          found = 0;
          for (int i = 1; i <= NUM_REQ; i++) begin
            w = (m_rr + i) % NUM_REQ;
            if (!found && req[w]) begin
              found = 1;
              byte_v = data[w*DATA_W +: DATA_W];
              m_bits.delete();
              m_bits.push_back(1'b0);
              for (int b = 0; b < DATA_W; b++) m_bits.push_back(byte_v[b]);
`ifdef UART_PARITY_EN
              m_bits.push_back(^byte_v);
`endif
              for (int s = 0; s < STOP_BITS; s++) m_bits.push_back(1'b1);
              m_owner = w; m_rr = w; e_gnt[w] = 1'b1; e_busy = 1'b1;
              m_active = 1; m_first = 1; m_k = 0;
            end
          end
        end
      end else if (m_first) begin
        m_first = 0;
      end else if (tk) begin
        if (m_k < int'(NBITS)) begin
          e_tx = m_bits[m_k];
          m_k++;
          m_sent = 1;
        end else begin
          e_done[m_owner] = 1'b1;
          e_tx = 1'b1;
          m_active = 0;
          m_done_pend = 1;
        end
      end
    end
  end

  // Compare process plus capture of line levels, grant order and frame width
  bit cap[$];
  int gord[$];
  int cyc = 0;
  int fall_cyc = 0;
  bit fall_armed = 0;
  always @(negedge clk) begin
    cyc++;
    if (cmp_en) begin
      check("tx", 32'(tx), 32'(e_tx));
      check("gnt", 32'(gnt), 32'(e_gnt));
      check("done", 32'(done), 32'(e_done));
      check("busy", 32'(busy), 32'(e_busy));
      if (m_sent) cap.push_back(tx);
      if (gnt != '0) begin
        for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) gord.push_back(i);
        fall_armed = 1;
      end
      if (fall_armed && tx == 1'b0) begin
        fall_cyc = cyc;
        fall_armed = 0;
      end
      if (done != '0 && width_en) check("frame_cycles", 32'(cyc - fall_cyc), 32'(NBITS * BIT_CYC));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(1);
  endtask

  task automatic wait_gnt(input string name, output logic [NUM_REQ-1:0] g);
    bit ok = 0;
    g = '0;
    for (int i = 0; i < BUDGET && !ok; i++) begin
      @(negedge clk);
      if (gnt != '0) begin ok = 1; g = gnt; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL %s timeout waiting for gnt", name); end
  endtask

  task automatic wait_done(input string name, input int budget, output logic [NUM_REQ-1:0] d);
    bit ok = 0;
    d = '0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (done != '0) begin ok = 1; d = done; end
    end
    if (!ok) begin checks++; errors++; $display("FAIL %s timeout waiting for done", name); end
  endtask

  task automatic wait_bits(input string name, input int k);
    bit ok = 0;
    for (int i = 0; i < BUDGET && !ok; i++) begin
      @(negedge clk);
      if (m_k >= k) ok = 1;
    end
    if (!ok) begin checks++; errors++; $display("FAIL %s timeout waiting for bit %0d", name, k); end
  endtask

  // Compare captured line levels of one frame against a literal list
  task automatic check_bits(input string name, input int base, input bit exp[$]);
    check({name, "_len"}, 32'(cap.size() - base), 32'(exp.size()));
    for (int i = 0; i < exp.size() && base + i < cap.size(); i++)
      check($sformatf("%s_bit%0d", name, i), 32'(cap[base+i]), 32'(exp[i]));
  endtask

  initial begin
    logic [NUM_REQ-1:0] g, d;
    bit exp[$];
    int base;
    logic held;
    bit seen_done;

    step(3);
    cmp_en = 1;
    rst = 1'b0;
    @(negedge clk);
    // 1: idle after reset
    check("t1_tx", 32'(tx), 32'h1);
    check("t1_gnt", 32'(gnt), 32'h0);
    check("t1_busy", 32'(busy), 32'h0);
    step(20 * BIT_CYC);
    check("t1_tx_hold", 32'(tx), 32'h1);
    check("t1_no_gnt", 32'(gord.size()), 32'h0);

    // 2: single frame of 8'hA5 from requester 0
    width_en = 1;
    data[7:0] = 8'hA5;
    base = cap.size();
    req = 4'b0001;
    wait_gnt("t2", g);
    check("t2_gnt", 32'(g), 32'h1);
    step(1);
    req = '0;
    wait_done("t2", BUDGET, d);
    check("t2_done", 32'(d), 32'h1);
    check("t2_busy_at_done", 32'(busy), 32'h1);
    @(negedge clk);
    check("t2_busy_after", 32'(busy), 32'h0);
    exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`ifdef UART_PARITY_EN
    exp.push_back(1'b0);
`endif
    for (int s = 0; s < STOP_BITS; s++) exp.push_back(1'b1);
    check_bits("t2", base, exp);

    // 3: all requesters held, round-robin order
    do_reset();
    data = {8'h44, 8'h33, 8'h22, 8'h11};
    base = gord.size();
    req = 4'b1111;
    for (int i = 0; i < 6 * BUDGET && gord.size() - base < 5; i++) @(negedge clk);
    step(1);
    req = '0;
    wait_done("t3", BUDGET, d);
    check("t3_ngrants", 32'(gord.size() - base), 32'd5);
    exp = '{};
    begin
      int order[5] = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5 && base + i < gord.size(); i++)
        check($sformatf("t3_grant%0d", i), 32'(gord[base+i]), 32'(order[i]));
    end
    step(3);

`ifdef UART_PARITY_EN
    // 4: parity bit values
    data[7:0] = 8'h07;
    base = cap.size();
    req = 4'b0001;
    wait_gnt("t4a", g);
    step(1);
    req = '0;
    wait_done("t4a", BUDGET, d);
    check("t4_len_07", 32'(cap.size() - base), 32'(NBITS));
    if (cap.size() > base + 9) check("t4_parity_07", 32'(cap[base+9]), 32'h1);
    step(3);
    data[7:0] = 8'h03;
    base = cap.size();
    req = 4'b0001;
    wait_gnt("t4b", g);
    step(1);
    req = '0;
    wait_done("t4b", BUDGET, d);
    if (cap.size() > base + 9) check("t4_parity_03", 32'(cap[base+9]), 32'h0);
    step(3);
`endif

    // 5: reset during data bit 4
    width_en = 0;
    data[7:0] = 8'h0F;
    req = 4'b0001;
    wait_gnt("t5", g);
    step(1);
    req = '0;
    wait_bits("t5", 6);
    check("t5_tx_low_before", 32'(tx), 32'h0);
    #1;
    rst = 1'b1;
    #1;
    check("t5_tx_reset", 32'(tx), 32'h1);
    seen_done = 0;
    for (int i = 0; i < int'(NBITS * BIT_CYC); i++) begin
      @(negedge clk);
      if (done != '0) seen_done = 1;
      if (i == 3) begin
        @(posedge clk);
        #2;
        rst = 1'b0;
      end
    end
    check("t5_no_done", 32'(seen_done), 32'h0);
    data[23:16] = 8'h5A;
    req = 4'b0100;
    wait_gnt("t5b", g);
    check("t5_gnt", 32'(g), 32'h4);
    step(1);
    req = '0;
    wait_done("t5b", BUDGET, d);
    check("t5_done", 32'(d), 32'h4);
    step(3);

    // 6: bclk stall mid-data
    data[7:0] = 8'h3C;
    base = cap.size();
    req = 4'b0001;
    wait_gnt("t6", g);
    step(1);
    req = '0;
    wait_bits("t6", 4);
    bclk_run = 1'b0;
    held = tx;
    repeat (100) @(negedge clk);
    check("t6_tx_held", 32'(tx), 32'(held));
    check("t6_busy_stall", 32'(busy), 32'h1);
    bclk_run = 1'b1;
    wait_done("t6", BUDGET, d);
    check("t6_done", 32'(d), 32'h1);
    exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`ifdef UART_PARITY_EN
    exp.push_back(1'b0);
`endif
    for (int s = 0; s < STOP_BITS; s++) exp.push_back(1'b1);
    check_bits("t6", base, exp);

    step(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
